// File: rtl/jtag_scan_master.sv
// Command-driven JTAG sequencer: turns reset / IR-scan / DR-scan commands into
// TCK/TMS/TDI activity and returns the TDO bits captured during the shift.
module jtag_scan_master #(
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = 9,
    parameter int TCK_DIV = 2
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    input  logic               cmd_pause,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [1:0] T_RST = 2'd0;
    localparam logic [1:0] T_IR  = 2'd1;
    localparam logic [1:0] T_DR  = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SHIFT, S_TRL, S_RSP} state_t;

    state_t             state, state_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [LEN_W-1:0]   bitc, bitc_nxt;
    logic [1:0]         typ_q;
    logic [LEN_W-1:0]   len_q;
    logic               pause_q;
    logic [MAX_LEN-1:0] dat_q, cap_q;
    logic               err_q;
    logic [DIV_W-1:0]   div_cnt;
    logic               tck_q, tms_q, tdi_q;
    logic               accept, cmd_bad, tick, rise, fall, tail, last_bit;
    logic [2:0]         hdr_len, trl_len;
    logic [7:0]         hdr_seq, trl_seq;
    logic               tms_nxt, tdi_nxt;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_HDR) || (state == S_SHIFT) || (state == S_TRL);
    assign rsp_valid = (state == S_RSP);
    assign rsp_err   = err_q & rsp_valid;
    assign rsp_data  = cap_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

    assign accept  = cmd_valid && cmd_ready;
    assign cmd_bad = (cmd_type == 2'd3) ||
                     ((cmd_type != T_RST) && ((cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN))));

    // TMS patterns, bit 0 goes out first
    always_comb begin
        hdr_len = 3'd3;
        hdr_seq = 8'b0000_0001;
        trl_len = 3'd2;
        trl_seq = 8'b0000_0001;
        case (typ_q)
            T_RST:   begin hdr_len = 3'd6; hdr_seq = 8'b0001_1111; end
            T_IR:    begin hdr_len = 3'd4; hdr_seq = 8'b0000_0011; end
            default: ;
        endcase
        if (typ_q == T_DR && pause_q) begin
            trl_len = 3'd4;
            trl_seq = 8'b0000_0110;
        end
    end

    assign tick     = (div_cnt == DIV_W'(TCK_DIV - 1));
    assign rise     = busy && tick && !tck_q;
    assign fall     = busy && tick && tck_q;
    // One extra low half-period after the last falling edge before responding
    assign tail     = ((state == S_HDR) && (idx == hdr_len)) ||
                      ((state == S_TRL) && (idx == trl_len));
    assign last_bit = (bitc == len_q - LEN_W'(1));

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        bitc_nxt  = bitc;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = cmd_bad ? S_RSP : S_HDR;
                    idx_nxt   = '0;
                    bitc_nxt  = '0;
                end
            end
            S_HDR: begin
                if (rise && tail) begin
                    state_nxt = S_RSP;
                end else if (fall) begin
                    if ((3'(idx + 3'd1) == hdr_len) && (typ_q != T_RST)) begin
                        state_nxt = S_SHIFT;
                        idx_nxt   = '0;
                        bitc_nxt  = '0;
                    end else begin
                        idx_nxt = 3'(idx + 3'd1);
                    end
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    if (last_bit) begin
                        state_nxt = S_TRL;
                        idx_nxt   = '0;
                    end else begin
                        bitc_nxt = bitc + LEN_W'(1);
                    end
                end
            end
            S_TRL: begin
                if (rise && tail)
                    state_nxt = S_RSP;
                else if (fall)
                    idx_nxt = 3'(idx + 3'd1);
            end
            S_RSP: begin
                if (rsp_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tms_nxt = tms_q;
        tdi_nxt = 1'b0;
        case (state_nxt)
            S_HDR:   tms_nxt = hdr_seq[idx_nxt];
            S_SHIFT: begin
                tms_nxt = (bitc_nxt == len_q - LEN_W'(1));
                tdi_nxt = dat_q[bitc_nxt[IDX_W-1:0]];
            end
            S_TRL:   tms_nxt = trl_seq[idx_nxt];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= S_IDLE;
            idx   <= '0;
            bitc  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            bitc  <= bitc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            typ_q   <= T_RST;
            len_q   <= '0;
            pause_q <= 1'b0;
            dat_q   <= '0;
            cap_q   <= '0;
            err_q   <= 1'b0;
            div_cnt <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else if (accept) begin
            typ_q   <= cmd_type;
            len_q   <= cmd_len;
            pause_q <= cmd_pause;
            dat_q   <= cmd_data;
            cap_q   <= '0;
            err_q   <= cmd_bad;
            div_cnt <= '0;
            tck_q   <= 1'b0;
            tdi_q   <= 1'b0;
            // every valid sequence opens with TMS=1, driven a half-period ahead of the first rise
            if (!cmd_bad)
                tms_q <= 1'b1;
        end else if (busy) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (rise && !tail) begin
                tck_q <= 1'b1;
                if (state == S_SHIFT)
                    cap_q[bitc[IDX_W-1:0]] <= tdo;
            end
            if (fall) begin
                tck_q <= 1'b0;
                tms_q <= tms_nxt;
                tdi_q <= tdi_nxt;
            end
        end
    end
endmodule
